// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: turns hazard, branch and memory-handshake
// inputs into PC and pipeline-register controls, with a watchdog and perf counters.
module pipeline_stall_controller #(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard_detected,
  input  logic                 branch_taken,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic                 mem_ready,
  input  logic                 perf_clear,
  output logic                 pc_freeze,
  output logic                 if_id_freeze,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 pipe_freeze,
  output logic                 mem_waiting,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic [CNT_WIDTH-1:0] mem_wait_count
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int                    WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0]     WAIT_MAX  = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  state_t              state;
  state_t              state_next;
  logic                mem_req;
  logic                mem_stall;
  logic                branch_act;
  logic                hazard_act;
  logic [WAIT_W-1:0]   wait_cnt;

  // A memory stall masks branch and hazard; branch beats hazard since the
  // hazarding instruction is squashed anyway.
  assign mem_req    = mem_r_en | mem_w_en;
  assign mem_stall  = mem_req & ~mem_ready;
  assign branch_act = ~mem_stall & branch_taken;
  assign hazard_act = ~mem_stall & ~branch_taken & hazard_detected;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:      if (mem_stall) state_next = MEM_WAIT;
      MEM_WAIT: if (mem_ready || !mem_req) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  assign mem_waiting = (state == MEM_WAIT);

  // Controls are combinational so release happens in the mem_ready cycle;
  // reset low masks them asynchronously.
  always_comb begin
    pc_freeze    = 1'b0;
    if_id_freeze = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        pipe_freeze  = 1'b1;
      end else if (branch_act) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (hazard_act) begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count    <= '0;
      flush_count    <= '0;
      mem_wait_count <= '0;
    end else if (perf_clear) begin
      stall_count    <= '0;
      flush_count    <= '0;
      mem_wait_count <= '0;
    end else begin
      if (hazard_act) stall_count    <= sat_inc(stall_count);
      if (branch_act) flush_count    <= sat_inc(flush_count);
      if (mem_stall)  mem_wait_count <= sat_inc(mem_wait_count);
    end
  end

  // Watchdog only reports; the pipeline stays frozen until memory answers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (!mem_stall) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (mem_stall && (wait_cnt >= WAIT_LAST)) begin
        mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed vectors push
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_pipeline_stall_controller;

  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          hazard_detected;
  logic          branch_taken;
  logic          mem_r_en;
  logic          mem_w_en;
  logic          mem_ready;
  logic          perf_clear;
  logic          pc_freeze;
  logic          if_id_freeze;
  logic          if_id_flush;
  logic          id_ex_bubble;
  logic          pipe_freeze;
  logic          mem_waiting;
  logic          mem_timeout;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;
  logic [CW-1:0] mem_wait_count;

  typedef struct {
    int            idx;
    logic [4:0]    ctrl;
    logic          mw;
    logic          mto;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic [CW-1:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   vec_idx = 0;
  bit   stim_done = 0;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_HAZ  = 5'b11010;
  localparam logic [4:0] C_BR   = 5'b00110;
  localparam logic [4:0] C_MEM  = 5'b11001;

  pipeline_stall_controller #(
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_r_en        (mem_r_en),
    .mem_w_en        (mem_w_en),
    .mem_ready       (mem_ready),
    .perf_clear      (perf_clear),
    .pc_freeze       (pc_freeze),
    .if_id_freeze    (if_id_freeze),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .pipe_freeze     (pipe_freeze),
    .mem_waiting     (mem_waiting),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .mem_wait_count  (mem_wait_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the rising edge and queue what the
  // monitor should see at the following falling edge.
  task automatic applyStimulus(
    input logic r, hz, br, rd, wr, rdy, clr,
    input logic [4:0] ctrl, input logic mw, mto,
    input logic [CW-1:0] sc, fc, mc
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; hazard_detected = hz; branch_taken = br;
    mem_r_en = rd; mem_w_en = wr; mem_ready = rdy; perf_clear = clr;
    e.idx = vec_idx; e.ctrl = ctrl; e.mw = mw; e.mto = mto;
    e.sc = sc; e.fc = fc; e.mc = mc;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [4:0] act;
    act = {pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, pipe_freeze};
    total++;
    if (act !== e.ctrl) begin
      bad++;
      $display("[TB] FAIL ctrl vec=%0d got=%b want=%b", e.idx, act, e.ctrl);
    end
    total++;
    if (mem_waiting !== e.mw) begin
      bad++;
      $display("[TB] FAIL mem_waiting vec=%0d got=%b want=%b", e.idx, mem_waiting, e.mw);
    end
    total++;
    if (mem_timeout !== e.mto) begin
      bad++;
      $display("[TB] FAIL mem_timeout vec=%0d got=%b want=%b", e.idx, mem_timeout, e.mto);
    end
    total++;
    if (stall_count !== e.sc) begin
      bad++;
      $display("[TB] FAIL stall_count vec=%0d got=%0d want=%0d", e.idx, stall_count, e.sc);
    end
    total++;
    if (flush_count !== e.fc) begin
      bad++;
      $display("[TB] FAIL flush_count vec=%0d got=%0d want=%0d", e.idx, flush_count, e.fc);
    end
    total++;
    if (mem_wait_count !== e.mc) begin
      bad++;
      $display("[TB] FAIL mem_wait_count vec=%0d got=%0d want=%0d", e.idx, mem_wait_count, e.mc);
    end
  endtask

  // Monitor: owns the counters, the drain bound and the summary line.
  initial begin
    int guard;
    exp_t e;
    guard = 0;
    while (!(stim_done && exp_q.size() == 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
    if (guard >= 2000) begin
      total++;
      bad++;
      $display("[TB] FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b0; hazard_detected = 1'b0; branch_taken = 1'b0;
    mem_r_en = 1'b0; mem_w_en = 1'b0; mem_ready = 1'b0; perf_clear = 1'b0;

    // reset held: controls forced low even with active inputs
    applyStimulus(0,0,0,0,0,0,0, C_NONE, 0,0, 0,0,0);
    applyStimulus(0,1,1,1,0,0,0, C_NONE, 0,0, 0,0,0);
    applyStimulus(1,0,0,0,0,0,0, C_NONE, 0,0, 0,0,0);

    // hazard for two cycles
    applyStimulus(1,1,0,0,0,0,0, C_HAZ,  0,0, 0,0,0);
    applyStimulus(1,1,0,0,0,0,0, C_HAZ,  0,0, 1,0,0);
    applyStimulus(1,0,0,0,0,0,0, C_NONE, 0,0, 2,0,0);

    // branch beats hazard
    applyStimulus(1,1,1,0,0,0,0, C_BR,   0,0, 2,0,0);
    applyStimulus(1,0,0,0,0,0,0, C_NONE, 0,0, 2,1,0);

    // five-cycle load wait, branch mid-wait ignored; watchdog (4) trips too
    applyStimulus(1,0,0,1,0,0,0, C_MEM,  0,0, 2,1,0);
    applyStimulus(1,0,0,1,0,0,0, C_MEM,  1,0, 2,1,1);
    applyStimulus(1,0,1,1,0,0,0, C_MEM,  1,0, 2,1,2);
    applyStimulus(1,0,0,1,0,0,0, C_MEM,  1,0, 2,1,3);
    applyStimulus(1,0,0,1,0,0,0, C_MEM,  1,1, 2,1,4);
    applyStimulus(1,0,0,1,0,1,0, C_NONE, 1,1, 2,1,5);
    applyStimulus(1,0,0,0,0,0,0, C_NONE, 0,1, 2,1,5);

    // asynchronous reset in the middle of a wait
    applyStimulus(1,0,0,1,0,0,0, C_MEM,  0,1, 2,1,5);
    applyStimulus(1,0,0,1,0,0,0, C_MEM,  1,1, 2,1,6);
    applyStimulus(0,0,0,1,0,0,0, C_NONE, 0,0, 0,0,0);
    applyStimulus(1,0,0,0,0,0,0, C_NONE, 0,0, 0,0,0);
    applyStimulus(1,0,0,0,0,0,0, C_NONE, 0,0, 0,0,0);

    // store stalled ten cycles: timeout after the 4th, wait count saturates at 7
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1,0,0,0,1,0,0, C_MEM, (i > 0), (i >= 4), 0, 0,
                    (i > 7) ? CW'(7) : CW'(i));
    end
    applyStimulus(1,0,0,0,0,0,1, C_NONE, 1,1, 0,0,7);
    applyStimulus(1,0,0,0,0,0,0, C_NONE, 0,1, 0,0,0);

    // hazard held ten cycles: stall count saturates, then clear beats increment
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1,1,0,0,0,0,0, C_HAZ, 0, 1, (i > 7) ? CW'(7) : CW'(i), 0, 0);
    end
    applyStimulus(1,1,0,0,0,0,1, C_HAZ,  0,1, 7,0,0);
    applyStimulus(1,0,0,0,0,0,0, C_NONE, 0,1, 0,0,0);

    // hazard masked by a stall, then applied on the ready cycle
    applyStimulus(1,1,0,1,0,0,0, C_MEM,  0,1, 0,0,0);
    applyStimulus(1,1,0,1,0,1,0, C_HAZ,  1,1, 0,0,1);
    applyStimulus(1,0,0,0,0,0,0, C_NONE, 0,1, 1,0,1);

    stim_done = 1;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the ID-stage hazard signal, the EXE-stage branch-taken signal and the SRAM/memory ready handshake.
- Turns them into freeze, flush and bubble controls for the PC and the IF/ID, ID/EX, EXE/MEM and MEM/WB pipeline registers.
- Owns the memory-wait state machine, a wait-timeout watchdog and saturating performance counters for stall, flush and memory-wait cycles.

Parameters:
- CNT_WIDTH, 16, width of each performance counter.
- TIMEOUT_CYCLES, 64, consecutive memory-wait cycles after which mem_timeout is raised.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- hazard_detected  input  1  RAW hazard from ID stage; request one stall cycle.
- branch_taken  input  1  taken branch resolved in EXE this cycle.
- mem_r_en  input  1  MEM-stage load request.
- mem_w_en  input  1  MEM-stage store request.
- mem_ready  input  1  memory completes the current access this cycle.
- perf_clear  input  1  synchronous clear of all performance counters.
- pc_freeze  output  1  hold PC.
- if_id_freeze  output  1  hold IF/ID register.
- if_id_flush  output  1  load NOP into IF/ID.
- id_ex_bubble  output  1  load NOP (all write/mem enables 0) into ID/EX.
- pipe_freeze  output  1  hold ID/EX, EXE/MEM and MEM/WB registers.
- mem_waiting  output  1  state is MEM_WAIT.
- mem_timeout  output  1  sticky watchdog error.
- stall_count  output  CNT_WIDTH  hazard stall cycles applied.
- flush_count  output  CNT_WIDTH  branch flushes applied.
- mem_wait_count  output  CNT_WIDTH  cycles frozen for memory.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; all counters 0; wait counter 0; mem_timeout=0.
  - All control outputs (pc_freeze … pipe_freeze) forced 0 while rst=0, regardless of inputs.
- mem_req = mem_r_en | mem_w_en.
- mem_stall = mem_req & ~mem_ready, evaluated in both RUN and MEM_WAIT (combinational, same cycle).
- States:
  - RUN:
    - if mem_stall, go to MEM_WAIT.
    - otherwise stay in RUN.
  - MEM_WAIT:
    - if mem_ready, or mem_req has dropped, go to RUN.
    - otherwise stay.
    - mem_waiting=1 only in MEM_WAIT (registered).
- Control priority, evaluated combinationally each cycle:
  1. mem_stall: pc_freeze=if_id_freeze=pipe_freeze=1; flush/bubble=0. Hazard and branch are ignored; the upstream hazard unit re-presents them after the freeze.
  2. Otherwise branch_taken: if_id_flush=1, id_ex_bubble=1, pc_freeze=0, if_id_freeze=0. Branch wins over a simultaneous hazard because the hazarding instruction is squashed.
  3. Otherwise hazard_detected: pc_freeze=1, if_id_freeze=1, id_ex_bubble=1.
  4. Otherwise all controls 0.
- On the cycle mem_ready=1, freezes drop in that same cycle so the pipeline advances and the access retires. Latency from mem_ready to release is 0 cycles.
- Counters:
  - Increment on rising edge when case 3 applies (stall_count), case 2 applies (flush_count) or case 1 applies (mem_wait_count).
  - Saturate at 2^CNT_WIDTH-1; no wrap.
  - perf_clear=1 zeroes all three on the next edge; clear wins over a same-cycle increment.
- Watchdog:
  - Wait counter increments each cycle mem_stall=1 and clears when mem_stall=0.
  - When it reaches TIMEOUT_CYCLES, mem_timeout is set. It stays set until reset; perf_clear does not clear it.
  - The pipeline stays frozen; the watchdog never forces release.
  - The wait counter saturates at TIMEOUT_CYCLES.
- Reset mid-wait: returns to RUN immediately; controls drop asynchronously.

Test Plan:
- Hazard only: hazard_detected=1 for 2 cycles, no mem_req → pc_freeze=if_id_freeze=id_ex_bubble=1 both cycles, stall_count=2, flush_count=0.
- Branch vs hazard: branch_taken=1 and hazard_detected=1 same cycle → if_id_flush=1, id_ex_bubble=1, pc_freeze=0, flush_count=1, stall_count unchanged.
- Memory wait: mem_r_en=1 with mem_ready low for 5 cycles then high → pipe_freeze=1 for 5 cycles, 0 on the ready cycle; mem_waiting=1 cycles 2–6; mem_wait_count=5; branch_taken pulsed mid-wait yields no flush.
- Timeout: TIMEOUT_CYCLES=4, mem_w_en=1, mem_ready=0 for 10 cycles → mem_timeout rises after 4th stalled cycle and stays 1; perf_clear then → counters 0, mem_timeout still 1.
- Saturation/clear: CNT_WIDTH=3, hazard held 10 cycles → stall_count stops at 7; perf_clear with hazard=1 same cycle → stall_count=0.
- Async reset: drop rst mid MEM_WAIT between edges → all controls and counters 0 immediately; after release with no inputs, state RUN, outputs 0.
